instruction_fetch_controller: RTL and testbench

- Sequences the combinational instruction memory (20-bit word address in, 32-bit instruction out).
- Owns the program counter and issues one fetch per cycle.
- Buffers fetched words, tagged with their PC, in a small queue toward decode with a valid/ready handshake.
- Handles redirects (jump/branch), halt and out-of-range fetch faults.

---
 rtl/instruction_fetch_controller.sv | 184 ++++++++++++++++++
 tb/tb_instruction_fetch_controller.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch_controller.sv
// Instruction fetch controller: owns the PC, reads one word per cycle from a
// zero-latency instruction memory and queues {pc, word} pairs toward decode.
// Handles redirects, halt, and out-of-range fetch faults.
//
// Decode handshake: instr_valid, instr and instr_pc show the queue head.
// A transfer happens on any rising edge where instr_valid and instr_ready are
// both 1. instr_valid never depends on instr_ready. While instr_valid is 1
// without a transfer, the head stays stable. The exceptions are a redirect,
// a halt or a reset, which discard the queue.
module instruction_fetch_controller #(
    parameter int ADDR_WIDTH  = 20,
    parameter int DATA_WIDTH  = 32,
    parameter int MEM_SIZE    = 150,
    parameter int QUEUE_DEPTH = 2,
    parameter int START_ADDR  = 0
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  enable,
    output logic [ADDR_WIDTH-1:0] mem_address,
    input  logic [DATA_WIDTH-1:0] mem_instruction,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_address,
    input  logic                  halt,
    output logic                  instr_valid,
    input  logic                  instr_ready,
    output logic [DATA_WIDTH-1:0] instr,
    output logic [ADDR_WIDTH-1:0] instr_pc,
    output logic                  fault,
    output logic [1:0]            state
);

    localparam int CW = $clog2(QUEUE_DEPTH + 1);
    localparam logic [CW-1:0]         DEPTH_C   = CW'(QUEUE_DEPTH);
    localparam logic [ADDR_WIDTH:0]   MEM_LIMIT = (ADDR_WIDTH + 1)'(MEM_SIZE);
    localparam logic [ADDR_WIDTH-1:0] START_C   = ADDR_WIDTH'(START_ADDR);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH  = 2'd1,
        HALTED = 2'd2,
        FAULT  = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic                  fault_q, fault_d;
    logic [CW-1:0]         count_q, count_d;
    logic [ADDR_WIDTH-1:0] qpc_q  [QUEUE_DEPTH];
    logic [ADDR_WIDTH-1:0] qpc_d  [QUEUE_DEPTH];
    logic [DATA_WIDTH-1:0] qins_q [QUEUE_DEPTH];
    logic [DATA_WIDTH-1:0] qins_d [QUEUE_DEPTH];

    logic          pop;
    logic          push;
    logic          flush;
    logic          pc_in_range;
    logic          redirect_in_range;
    logic          room;
    logic [CW-1:0] widx;

    // Queue entry 0 is the head, so the decode outputs come straight from flops.
    assign instr_valid = (count_q != '0);
    assign instr       = qins_q[0];
    assign instr_pc    = qpc_q[0];
    assign mem_address = pc_q;
    assign fault       = fault_q;
    assign state       = state_q;

    assign pop               = instr_valid & instr_ready;
    assign pc_in_range       = ({1'b0, pc_q} < MEM_LIMIT);
    assign redirect_in_range = ({1'b0, redirect_address} < MEM_LIMIT);
    assign room              = (count_q < DEPTH_C) | pop;

    // Next-state logic: PC, fault flag, push/flush decisions.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        fault_d = fault_q;
        push    = 1'b0;
        flush   = 1'b0;
        case (state_q)
            IDLE: begin
                if (redirect_valid) begin
                    pc_d  = redirect_address;
                    flush = 1'b1;
                end else if (enable) begin
                    state_d = FETCH;
                end
            end
            FETCH: begin
                if (halt) begin
                    // Halt wins over a simultaneous redirect, but the target is kept.
                    state_d = HALTED;
                    flush   = 1'b1;
                    if (redirect_valid) pc_d = redirect_address;
                end else if (redirect_valid) begin
                    pc_d  = redirect_address;
                    flush = 1'b1;
                end else if (enable) begin
                    if (!pc_in_range) begin
                        // Existing entries keep draining; only fetching stops.
                        state_d = FAULT;
                        fault_d = 1'b1;
                    end else if (room) begin
                        push = 1'b1;
                        pc_d = pc_q + 1'b1;
                    end
                end
            end
            HALTED: begin
                if (redirect_valid) begin
                    pc_d  = redirect_address;
                    flush = 1'b1;
                    if (!halt) state_d = FETCH;
                end
            end
            FAULT: begin
                if (redirect_valid) begin
                    pc_d  = redirect_address;
                    flush = 1'b1;
                    if (redirect_in_range) begin
                        state_d = FETCH;
                        fault_d = 1'b0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Queue update: pop shifts the head out, push writes behind the survivors.
    always_comb begin
        qpc_d   = qpc_q;
        qins_d  = qins_q;
        count_d = count_q;
        widx    = pop ? (count_q - CW'(1)) : count_q;
        if (flush) begin
            count_d = '0;
        end else begin
            if (pop) begin
                for (int i = 0; i < QUEUE_DEPTH - 1; i++) begin
                    qpc_d[i]  = qpc_q[i+1];
                    qins_d[i] = qins_q[i+1];
                end
            end
            if (push) begin
                for (int i = 0; i < QUEUE_DEPTH; i++) begin
                    if (CW'(i) == widx) begin
                        qpc_d[i]  = pc_q;
                        qins_d[i] = mem_instruction;
                    end
                end
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // State, PC and queue registers with asynchronous active-low reset.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            pc_q    <= START_C;
            fault_q <= 1'b0;
            count_q <= '0;
            for (int i = 0; i < QUEUE_DEPTH; i++) begin
                qpc_q[i]  <= '0;
                qins_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            fault_q <= fault_d;
            count_q <= count_d;
            qpc_q   <= qpc_d;
            qins_q  <= qins_d;
        end
    end

endmodule

// File: tb/tb_instruction_fetch_controller.sv
// Directed bench for instruction_fetch_controller with a combinational
// instruction memory holding word[i] = 32'hA000_0000 + i.
module tb_instruction_fetch_controller;

  logic        clock;
  logic        reset_n;
  logic        enable;
  logic [19:0] mem_address;
  logic [31:0] mem_instruction;
  logic        redirect_valid;
  logic [19:0] redirect_address;
  logic        halt;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [19:0] instr_pc;
  logic        fault;
  logic [1:0]  state;

  int n_checks = 0;
  int n_pass   = 0;

  instruction_fetch_controller dut (
    .clock            (clock),
    .reset_n          (reset_n),
    .enable           (enable),
    .mem_address      (mem_address),
    .mem_instruction  (mem_instruction),
    .redirect_valid   (redirect_valid),
    .redirect_address (redirect_address),
    .halt             (halt),
    .instr_valid      (instr_valid),
    .instr_ready      (instr_ready),
    .instr            (instr),
    .instr_pc         (instr_pc),
    .fault            (fault),
    .state            (state)
  );

  // Clock and bench memory.
  initial clock = 1'b0;
  always #5 clock = ~clock;
  assign mem_instruction = 32'hA000_0000 + {12'd0, mem_address};

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Advance one edge and land 1 time unit after it.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic head_is(input string tag, input int pc);
    check({tag, "_valid"}, 64'(instr_valid), 64'd1);
    check({tag, "_pc"}, 64'(instr_pc), 64'(pc));
    check({tag, "_instr"}, 64'(instr), 64'(32'hA000_0000 + pc));
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #7;
    check("rst_state", 64'(state), 64'd0);
    check("rst_valid", 64'(instr_valid), 64'd0);
    check("rst_fault", 64'(fault), 64'd0);
    check("rst_addr", 64'(mem_address), 64'd0);
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0; enable = 1'b0; instr_ready = 1'b0;
    redirect_valid = 1'b0; redirect_address = '0; halt = 1'b0;
    #12;
    check("rst_instr", 64'(instr), 64'd0);
    check("rst_instr_pc", 64'(instr_pc), 64'd0);
    check("rst_state0", 64'(state), 64'd0);
    reset_n = 1'b1;                      // released at t=12, next edge t=15

    // Streaming: FETCH after the first edge, then 0,1,2,3 with no gaps.
    enable = 1'b1; instr_ready = 1'b1;
    tick();
    check("start_state", 64'(state), 64'd1);
    check("start_valid", 64'(instr_valid), 64'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      head_is("stream", i);
    end

    // Back-pressure: queue fills with pc 0,1 and PC holds at 2.
    @(negedge clock);
    do_reset();
    @(posedge clock); #1;
    instr_ready = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    head_is("bp_hold", 0);
    check("bp_addr", 64'(mem_address), 64'd2);
    instr_ready = 1'b1;
    for (int i = 1; i < 6; i++) begin
      tick();
      head_is("bp_drain", i);
    end
    check("bp_queue_addr", 64'(mem_address), 64'd7);

    // Redirect while pc 5,6 are queued: both discarded, target follows.
    redirect_valid = 1'b1; redirect_address = 20'd24;
    tick();
    redirect_valid = 1'b0;
    check("redir_valid", 64'(instr_valid), 64'd0);
    check("redir_addr", 64'(mem_address), 64'd24);
    tick();
    head_is("redir_tgt", 24);
    tick();
    head_is("redir_next", 25);

    // Fetch near the end of memory: 147..149 then fault, no pc 150.
    redirect_valid = 1'b1; redirect_address = 20'd147;
    tick();
    redirect_valid = 1'b0;
    for (int i = 147; i < 150; i++) begin
      tick();
      head_is("edge", i);
    end
    tick();
    check("flt_valid", 64'(instr_valid), 64'd0);
    check("flt_fault", 64'(fault), 64'd1);
    check("flt_state", 64'(state), 64'd3);
    tick();
    check("flt_sticky", 64'(fault), 64'd1);
    check("flt_noval", 64'(instr_valid), 64'd0);
    redirect_valid = 1'b1; redirect_address = 20'd5;
    tick();
    redirect_valid = 1'b0;
    check("rec_fault", 64'(fault), 64'd0);
    check("rec_state", 64'(state), 64'd1);
    tick();
    head_is("rec", 5);

    // Halt pulse: flush, HALTED, PC frozen at 6.
    halt = 1'b1;
    tick();
    halt = 1'b0;
    check("halt_valid", 64'(instr_valid), 64'd0);
    check("halt_state", 64'(state), 64'd2);
    check("halt_addr", 64'(mem_address), 64'd6);
    tick();
    check("halt_frozen", 64'(mem_address), 64'd6);
    check("halt_stay", 64'(state), 64'd2);
    redirect_valid = 1'b1; redirect_address = 20'd10;
    tick();
    redirect_valid = 1'b0;
    check("resume_state", 64'(state), 64'd1);
    tick();
    head_is("resume", 10);

    // Halt and redirect together from FETCH: HALTED, PC takes the target.
    halt = 1'b1; redirect_valid = 1'b1; redirect_address = 20'd24;
    tick();
    halt = 1'b0; redirect_valid = 1'b0;
    check("hr_state", 64'(state), 64'd2);
    check("hr_addr", 64'(mem_address), 64'd24);
    check("hr_valid", 64'(instr_valid), 64'd0);
    tick();
    check("hr_stay", 64'(state), 64'd2);
    redirect_valid = 1'b1; redirect_address = 20'd30;
    tick();
    redirect_valid = 1'b0;
    tick();
    head_is("hr_resume", 30);
    tick();
    head_is("hr_resume2", 31);

    // Asynchronous reset between edges, mid-stream.
    #3;
    reset_n = 1'b0;
    #1;
    check("arst_valid", 64'(instr_valid), 64'd0);
    check("arst_state", 64'(state), 64'd0);
    check("arst_fault", 64'(fault), 64'd0);
    check("arst_addr", 64'(mem_address), 64'd0);
    #1;
    reset_n = 1'b1;
    tick();
    check("arst_fetch", 64'(state), 64'd1);
    check("arst_empty", 64'(instr_valid), 64'd0);
    tick();
    head_is("arst_restart", 0);
    tick();
    head_is("arst_restart1", 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
